serial_adder: RTL and testbench

- Bit-serial ripple adder: accepts two WIDTH-bit operands plus carry-in on a start pulse.
- Adds one bit per clock, LSB first, through a single full-adder cell with a registered carry.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Serves as the area-minimal sequential arithmetic stage consuming the team's combinational adder cells.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_full_adder_cell.sv | 59 +++++
 rtl/serial_adder.sv | 151 +++++++++++++++
 tb/tb_serial_adder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder.
//   - state_t       : controller states (IDLE, SHIFT, DONE)
//   - DEFAULT_WIDTH : operand width used when the top is not overridden
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_cell.sv
// ---------------------------------------------------------------------------
// half_adder / full_adder_cell
//   Combinational adder cells consumed by the bit-serial adder.
//
//   half_adder ports:
//     a, b  in  1  addend bits
//     s     out 1  a ^ b
//     c     out 1  a & b
//
//   full_adder_cell ports:
//     a, b  in  1  addend bits
//     ci    in  1  carry in
//     s     out 1  sum bit
//     co    out 1  carry out (majority of a, b, ci)
//
//   The full adder is built from two half adders; the two half-adder carries
//   can never both be 1, so a plain OR merges them into the carry out.
// ---------------------------------------------------------------------------
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (ci),
    .s (s),
    .c (c1)
  );

  assign co = c0 | c1;

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial ripple adder. On an accepted start the operands and carry-in
//   are captured, then one bit per clock (LSB first) is pushed through a
//   single full_adder_cell with a registered carry. After WIDTH shift cycles
//   the result is copied to sum/cout and done pulses for one cycle.
//
//   Parameter:
//     WIDTH  operand/sum width, 2..32 (default 8)
//
//   Ports:
//     clk    in   1      rising-edge clock
//     rst_n  in   1      synchronous active-low reset
//     start  in   1      request pulse, honoured only in IDLE
//     a, b   in   WIDTH  operands, captured on accepted start
//     cin    in   1      carry in, captured on accepted start
//     busy   out  1      high whenever the controller is not IDLE
//     done   out  1      one-cycle pulse, sum/cout valid
//     sum    out  WIDTH  registered result, held until the next completion
//     cout   out  1      registered carry out, held like sum
//     ovf    out  1      signed overflow, only when SERIAL_ADDER_OVF_EN is
//                        defined; registered and held like cout
//
//   Optional build macro: SERIAL_ADDER_OVF_EN
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               fa_s;
  logic               fa_co;
  logic               last_bit;

  full_adder_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CNT_LAST);

  // Next-state and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          // Sum bits enter at the MSB so that after WIDTH shifts bit 0 of
          // the result sits in res_sr[0].
          res_sr  <= {fa_s, res_sr[WIDTH-1:1]};
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          carry_q <= fa_co;
          if (last_bit) begin
            // The final bit is still in flight, so the completed word is
            // assembled from the cell output rather than from res_sr.
            cnt_q <= '0;
            sum   <= {fa_s, res_sr[WIDTH-1:1]};
            cout  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q here is the carry into the MSB position.
            ovf   <= carry_q ^ fa_co;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Directed and randomised checks of serial_adder at WIDTH=8 and WIDTH=13.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  logic        clk;
  logic        rst_n;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        cin8;
  logic        busy8;
  logic        done8;
  logic [7:0]  sum8;
  logic        cout8;

  logic        start13;
  logic [12:0] a13;
  logic [12:0] b13;
  logic        cin13;
  logic        busy13;
  logic        done13;
  logic [12:0] sum13;
  logic        cout13;

`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf8;
  logic        ovf13;
`endif

  int n_checks;
  int n_fail;
  int starts8;
  int dones8;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_adder #(.WIDTH(13)) dut13 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start13),
    .a     (a13),
    .b     (b13),
    .cin   (cin13),
    .busy  (busy13),
    .done  (done13),
    .sum   (sum13),
    .cout  (cout13)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf13)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done8) dones8 <= dones8 + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One 8-bit operation. With poke set, start is re-asserted with other
  // operands in shift cycle 3 and in the DONE cycle; both must be ignored.
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic ci, input bit poke);
    logic [8:0] exp;
    logic [7:0] low;
    logic [8:0] prev;
    int         n;
    bit         seen;
    exp  = {1'b0, av} + {1'b0, bv} + {8'd0, ci};
    low  = {1'b0, av[6:0]} + {1'b0, bv[6:0]} + {7'd0, ci};
    prev = {cout8, sum8};
    a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
    starts8++;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    check_eq("busy_after_start8", busy8, 1);
    n = 1;
    seen = 0;
    while (!seen && n < 40) begin
      if (done8) begin
        seen = 1;
      end else begin
        check_eq("result_held8", {cout8, sum8}, prev);
        if (poke && n == 3) begin
          start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        end else begin
          start8 = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    check_eq("done_seen8", seen, 1);
    // done first visible in the cycle after the WIDTH-th shift edge,
    // i.e. WIDTH+1 cycles counted from the accepting edge.
    check_eq("done_latency8", n, 9);
    check_eq("sum_cout8", {cout8, sum8}, exp);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("ovf8", ovf8, low[7] ^ exp[8]);
`endif
    if (poke) begin
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    end
    @(negedge clk);
    start8 = 1'b0;
    check_eq("done_single8", done8, 0);
    check_eq("idle_after8", busy8, 0);
  endtask

  task automatic run_op13(input logic [12:0] av, input logic [12:0] bv, input logic ci);
    logic [13:0] exp;
    logic [12:0] low;
    int          n;
    bit          seen;
    exp = {1'b0, av} + {1'b0, bv} + {13'd0, ci};
    low = {1'b0, av[11:0]} + {1'b0, bv[11:0]} + {12'd0, ci};
    a13 = av; b13 = bv; cin13 = ci; start13 = 1'b1;
    @(negedge clk);
    start13 = 1'b0;
    a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
    n = 1;
    seen = 0;
    while (!seen && n < 60) begin
      if (done13) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("done_seen13", seen, 1);
    check_eq("done_latency13", n, 14);
    check_eq("sum_cout13", {cout13, sum13}, exp);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("ovf13", ovf13, low[12] ^ exp[13]);
`endif
    @(negedge clk);
    check_eq("done_single13", done13, 0);
    check_eq("idle_after13", busy13, 0);
  endtask

  initial begin
    bit saw_done;
    n_checks = 0; n_fail = 0; starts8 = 0; dones8 = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy8, 0);
    check_eq("rst_done", done8, 0);
    check_eq("rst_sum", sum8, 0);
    check_eq("rst_cout", cout8, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("rst_ovf", ovf8, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_op8(8'h3C, 8'h05, 1'b0, 0);
    check_eq("v1_sum", sum8, 8'h41);
    run_op8(8'hFF, 8'h01, 1'b0, 0);
    check_eq("v2_sum", sum8, 8'h00);
    check_eq("v2_cout", cout8, 1);
    run_op8(8'hFF, 8'hFF, 1'b1, 0);
    repeat (20) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
    end
    check_eq("hold_sum", sum8, 8'hFF);
    check_eq("hold_cout", cout8, 1);
    check_eq("hold_busy", busy8, 0);

`ifdef SERIAL_ADDER_OVF_EN
    run_op8(8'h7F, 8'h00, 1'b1, 0);
    check_eq("ovf_pos_sum", sum8, 8'h80);
    check_eq("ovf_pos_flag", {cout8, ovf8}, 2'b01);
    run_op8(8'h80, 8'h80, 1'b0, 0);
    check_eq("ovf_neg_sum", sum8, 8'h00);
    check_eq("ovf_neg_flag", {cout8, ovf8}, 2'b11);
`endif

    // Start while busy must be ignored
    run_op8(8'h10, 8'h20, 1'b0, 1);
    check_eq("busy_ignore_sum", sum8, 8'h30);

    // Reset in the middle of an operation
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_busy", busy8, 0);
    check_eq("midrst_done", done8, 0);
    check_eq("midrst_sum", sum8, 0);
    check_eq("midrst_cout", cout8, 0);
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1;
    end
    check_eq("midrst_quiet", saw_done, 0);
    run_op8(8'h02, 8'h03, 1'b0, 0);
    check_eq("after_rst_sum", sum8, 8'h05);

    // Random operations with random idle gaps
    for (int i = 0; i < 1000; i++) begin
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int i = 0; i < 1000; i++) begin
      run_op13(13'($urandom), 13'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check_eq("done_count8", dones8, starts8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_adder
